// File: rtl/mul_sequencer_if.sv
// Request/result bundle between the MiniAlu MUL path and mul_sequencer.
// master = ALU side (drives the request), slave = sequencer side.
interface mul_sequencer_if;
    logic        iStart;
    logic [15:0] iA;
    logic [15:0] iB;
    logic [1:0]  iSel;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oProduct;
    logic [15:0] oResult;

    modport master (
        output iStart, iA, iB, iSel,
        input  oBusy, oDone, oProduct, oResult
    );

    modport slave (
        input  iStart, iA, iB, iSel,
        output oBusy, oDone, oProduct, oResult
    );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-4 multi-cycle 16x16 multiplier: one 2-bit multiplier digit per RUN cycle.
// Optional MULSEQ_EARLY_EXIT_EN ends RUN once the remaining multiplier digits are all zero.
module mul_sequencer (
    input  logic           Clock,
    input  logic           Reset,
    mul_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      stateReg;
    state_t      stateNext;

    logic [15:0] rA;
    logic [15:0] rB;
    logic [31:0] rAcc;
    logic [2:0]  rCnt;
    logic [1:0]  rSel;

    logic        accept;
    logic        lastIter;
    logic [17:0] partial;
    logic [31:0] shiftedPartial;
    logic [31:0] accSum;
    logic [15:0] aShifted;

    // Starts are only honoured between operations; a strobe during RUN is dropped.
    assign accept = bus.iStart && ((stateReg == IDLE) || (stateReg == DONE));

    always_comb begin
        partial = 18'd0;
        case (rA[1:0])
            2'd0: partial = 18'd0;
            2'd1: partial = {2'b00, rB};
            2'd2: partial = {1'b0, rB, 1'b0};
            2'd3: partial = {1'b0, rB, 1'b0} + {2'b00, rB};
            default: partial = 18'd0;
        endcase
    end

    assign shiftedPartial = 32'(partial) << {rCnt, 1'b0};
    assign accSum         = rAcc + shiftedPartial;
    assign aShifted       = {2'b00, rA[15:2]};

`ifdef MULSEQ_EARLY_EXIT_EN
    // Current digit is always accumulated; stop when nothing is left above it.
    assign lastIter = (rCnt == 3'd7) || (aShifted == 16'd0);
`else
    assign lastIter = (rCnt == 3'd7);
`endif

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (accept) stateNext = RUN;
            RUN:  if (lastIter) stateNext = DONE;
            DONE: stateNext = accept ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stateReg <= IDLE;
            rA       <= 16'd0;
            rB       <= 16'd0;
            rAcc     <= 32'd0;
            rCnt     <= 3'd0;
            rSel     <= 2'd0;
        end else begin
            stateReg <= stateNext;
            if (accept) begin
                rA   <= bus.iA;
                rB   <= bus.iB;
                rSel <= bus.iSel;
                rAcc <= 32'd0;
                rCnt <= 3'd0;
            end else if (stateReg == RUN) begin
                rAcc <= accSum;
                rA   <= aShifted;
                rCnt <= rCnt + 3'd1;
            end
        end
    end

    // Outputs come only from registered state; rAcc holds the product from DONE onward.
    assign bus.oBusy    = (stateReg == RUN);
    assign bus.oDone    = (stateReg == DONE);
    assign bus.oProduct = rAcc;

    always_comb begin
        bus.oResult = 16'd0;
        case (rSel)
            2'd0: bus.oResult = rAcc[15:0];
            2'd1: bus.oResult = rAcc[23:8];
            2'd2: bus.oResult = rAcc[31:16];
            2'd3: bus.oResult = {8'b0, rAcc[31:24]};
            default: bus.oResult = 16'd0;
        endcase
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer; expected values are hand-computed.
// Latency expectations follow MULSEQ_EARLY_EXIT_EN when that macro is defined.
module tb_mul_sequencer;

    logic Clock;
    logic Reset;
    int   numChecks;
    int   numErrors;

    mul_sequencer_if bus ();

    mul_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One multiply transaction. preStarted: the previous call already drove the start
    // during its DONE cycle. chain: drive the next start during this DONE cycle.
    task automatic runOp(input string name,
                         input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                         input logic [31:0] expProd, input logic [15:0] expRes,
                         input int latDefault, input int latEarly, input int glitchAt,
                         input bit preStarted, input bit chain,
                         input logic [15:0] nA, input logic [15:0] nB, input logic [1:0] nSel);
        int busyCnt;
        int lat;
        bit seen;
`ifdef MULSEQ_EARLY_EXIT_EN
        lat = latEarly;
`else
        lat = latDefault;
`endif
        if (!preStarted) begin
            @(negedge Clock);
            bus.iStart = 1'b1;
            bus.iA     = a;
            bus.iB     = b;
            bus.iSel   = sel;
        end
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        bus.iA     = 16'($urandom);
        bus.iB     = 16'($urandom);
        bus.iSel   = 2'($urandom);
        busyCnt = 0;
        seen    = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge Clock);
            checkValue({name, "_busy_and_done"}, 32'(bus.oBusy & bus.oDone), 32'd0);
            if (glitchAt == k) begin
                bus.iStart = 1'b1;
                bus.iA     = 16'd7;
            end else if (glitchAt == k - 1) begin
                bus.iStart = 1'b0;
            end
            if (bus.oDone) seen = 1'b1;
            else if (bus.oBusy) busyCnt++;
        end
        bus.iStart = 1'b0;
        checkValue({name, "_done_seen"}, 32'(seen), 32'd1);
        checkValue({name, "_busy_cycles"}, 32'(busyCnt), 32'(lat));
        checkValue({name, "_product"}, bus.oProduct, expProd);
        checkValue({name, "_result"}, 32'(bus.oResult), 32'(expRes));
        $display("op %s: a=0x%04h b=0x%04h sel=%0d -> product 0x%08h result 0x%04h busy %0d",
                 name, a, b, sel, bus.oProduct, bus.oResult, busyCnt);
        if (chain) begin
            bus.iStart = 1'b1;
            bus.iA     = nA;
            bus.iB     = nB;
            bus.iSel   = nSel;
        end else begin
            @(negedge Clock);
            checkValue({name, "_done_single"}, 32'(bus.oDone), 32'd0);
            checkValue({name, "_idle_busy"}, 32'(bus.oBusy), 32'd0);
            checkValue({name, "_product_hold"}, bus.oProduct, expProd);
            checkValue({name, "_result_hold"}, 32'(bus.oResult), 32'(expRes));
        end
    endtask

    initial begin
        int doneCnt;
        numChecks  = 0;
        numErrors  = 0;
        Reset      = 1'b0;
        bus.iStart = 1'b0;
        bus.iA     = 16'd0;
        bus.iB     = 16'd0;
        bus.iSel   = 2'd0;

        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkValue("reset_busy", 32'(bus.oBusy), 32'd0);
        checkValue("reset_done", 32'(bus.oDone), 32'd0);
        checkValue("reset_product", bus.oProduct, 32'd0);
        checkValue("reset_result", 32'(bus.oResult), 32'd0);
        $display("reset: busy=%0d done=%0d product=0x%08h", bus.oBusy, bus.oDone, bus.oProduct);
        Reset = 1'b1;
        @(negedge Clock);

        runOp("small", 16'd3, 16'd5, 2'd0, 32'h0000_000F, 16'h000F, 8, 1, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("max_sel0", 16'hFFFF, 16'hFFFF, 2'd0, 32'hFFFE_0001, 16'h0001, 8, 8, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("max_sel1", 16'hFFFF, 16'hFFFF, 2'd1, 32'hFFFE_0001, 16'hFE00, 8, 8, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("max_sel2", 16'hFFFF, 16'hFFFF, 2'd2, 32'hFFFE_0001, 16'hFFFE, 8, 8, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("max_sel3", 16'hFFFF, 16'hFFFF, 2'd3, 32'hFFFE_0001, 16'h00FF, 8, 8, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("glitch", 16'h1234, 16'h0010, 2'd0, 32'h0001_2340, 16'h2340, 8, 7, 2, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("zero_a", 16'h0000, 16'h5555, 2'd2, 32'h0000_0000, 16'h0000, 8, 1, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("one_a", 16'h0001, 16'hABCD, 2'd0, 32'h0000_ABCD, 16'hABCD, 8, 1, -1, 0, 0, 16'd0, 16'd0, 2'd0);
        runOp("bit8_a", 16'h0100, 16'hABCD, 2'd1, 32'h00AB_CD00, 16'hABCD, 8, 5, -1, 0, 0, 16'd0, 16'd0, 2'd0);

        // Back-to-back: second request held during the first DONE cycle.
        runOp("b2b_first", 16'h1234, 16'h0010, 2'd2, 32'h0001_2340, 16'h0001, 8, 7, -1, 0, 1, 16'd2, 16'd9, 2'd0);
        runOp("b2b_second", 16'd2, 16'd9, 2'd0, 32'h0000_0012, 16'h0012, 8, 1, -1, 1, 0, 16'd0, 16'd0, 2'd0);

        // Reset in the middle of a run: start at E0, reset sampled at E4.
        @(negedge Clock);
        bus.iStart = 1'b1;
        bus.iA     = 16'h1234;
        bus.iB     = 16'h0010;
        bus.iSel   = 2'd0;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        checkValue("midreset_running", 32'(bus.oBusy), 32'd1);
        Reset = 1'b0;
        @(negedge Clock);
        checkValue("midreset_busy", 32'(bus.oBusy), 32'd0);
        checkValue("midreset_done", 32'(bus.oDone), 32'd0);
        checkValue("midreset_product", bus.oProduct, 32'd0);
        checkValue("midreset_result", 32'(bus.oResult), 32'd0);
        $display("midreset: busy=%0d done=%0d product=0x%08h", bus.oBusy, bus.oDone, bus.oProduct);
        Reset   = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clock);
            if (bus.oDone) doneCnt++;
        end
        checkValue("midreset_no_done", 32'(doneCnt), 32'd0);
        runOp("after_reset", 16'h00FF, 16'h0101, 2'd1, 32'h0000_FFFF, 16'h00FF, 8, 4, -1, 0, 0, 16'd0, 16'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
